// File: rtl/mem_arbiter.sv
// Two-master arbiter for a shared program memory: one access at a time, two cycles per access.
// Define MEM_ARBITER_RR_EN for round-robin arbitration; otherwise m0 has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic                m0_rstrb,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_done,
  output logic                m0_busy,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_rstrb,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_done,
  output logic                m1_busy,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_rstrb,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          grant
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                rstrb_q, rstrb_d;
  logic                rd_q, rd_d;
  logic [1:0]          grant_q, grant_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                req0, req1, cand0, cand1, win0, win1, done0, done1;

  assign req0 = m0_rstrb | (|m0_wstrb);
  assign req1 = m1_rstrb | (|m1_wstrb);

  // A lone request still held by the master completing in DONE is its finished access, not a new one.
  assign cand0 = req0 & ~((state_q == DONE) & grant_q[0] & ~req1);
  assign cand1 = req1 & ~((state_q == DONE) & grant_q[1] & ~req0);

`ifdef MEM_ARBITER_RR_EN
  logic rr_q, rr_d;

  always_comb begin
    rr_d = rr_q;
    if (win0) rr_d = 1'b1;
    if (win1) rr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end
`endif

  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
    if (state_q != ACCESS) begin
      if (cand0 && cand1) begin
`ifdef MEM_ARBITER_RR_EN
        win0 = ~rr_q;
        win1 = rr_q;
`else
        win0 = 1'b1;
`endif
      end else begin
        win0 = cand0;
        win1 = cand1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rstrb_q  <= 1'b0;
      rd_q     <= 1'b0;
      grant_q  <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rstrb_q  <= rstrb_d;
      rd_q     <= rd_d;
      grant_q  <= grant_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: state_d = (win0 || win1) ? ACCESS : IDLE;
      ACCESS:     state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // A reset arriving in DONE suppresses the completion as well as the capture.
  assign done0 = (state_q == DONE) & grant_q[0] & ~rst;
  assign done1 = (state_q == DONE) & grant_q[1] & ~rst;

  always_comb begin
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rstrb_d  = rstrb_q;
    rd_d     = rd_q;
    grant_d  = grant_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (done0 && rd_q) rdata0_d = s_rdata;
    if (done1 && rd_q) rdata1_d = s_rdata;
    if (win0 || win1) begin
      addr_d  = win1 ? m1_addr  : m0_addr;
      wdata_d = win1 ? m1_wdata : m0_wdata;
      wstrb_d = win1 ? m1_wstrb : m0_wstrb;
      rstrb_d = win1 ? m1_rstrb : m0_rstrb;
      rd_d    = win1 ? m1_rstrb : m0_rstrb;
      grant_d = {win1, win0};
    end else if (state_q == ACCESS) begin
      rstrb_d = 1'b0;
      wstrb_d = '0;
    end else begin
      grant_d = 2'b00;
    end
  end

  assign s_addr   = addr_q;
  assign s_wdata  = wdata_q;
  assign s_wstrb  = wstrb_q;
  assign s_rstrb  = rstrb_q;
  assign grant    = grant_q;
  assign m0_done  = done0;
  assign m1_done  = done1;

  // Read data is forwarded in the completion cycle and held in the register afterwards.
  assign m0_rdata = (done0 && rd_q) ? s_rdata : rdata0_q;
  assign m1_rdata = (done1 && rd_q) ? s_rdata : rdata1_q;

  assign m0_busy  = req0 & ~win0 & ~(((state_q == ACCESS) || (state_q == DONE)) & grant_q[0]);
  assign m1_busy  = req1 & ~win1 & ~(((state_q == ACCESS) || (state_q == DONE)) & grant_q[1]);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random two-master episodes
// checked against a transaction-level model of arbitration order and memory contents.
module tb_mem_arbiter;

`ifdef MEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic        m0_rstrb = 1'b0, m1_rstrb = 1'b0;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_done, m1_done, m0_busy, m1_busy;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_rstrb;
  logic [31:0] s_rdata;
  logic [1:0]  grant;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] slaveMem [16];
  logic [31:0] refMem [16];
  logic [31:0] expRd [2];
  bit          favour1;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rstrb(m0_rstrb),
    .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_busy(m0_busy),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rstrb(m1_rstrb),
    .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_busy(m1_busy),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rstrb(s_rstrb),
    .s_rdata(s_rdata), .grant(grant)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] initWord(input int i);
    return (i == 4) ? 32'hDEADBEEF : (32'(i) * 32'h01010101) ^ 32'h5A000000;
  endfunction

  // Memory slave: read data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) slaveMem[i] <= initWord(i);
      s_rdata <= '0;
    end else begin
      if (s_rstrb) s_rdata <= slaveMem[s_addr[5:2]];
      for (int b = 0; b < 4; b++)
        if (s_wstrb[b]) slaveMem[s_addr[5:2]][8*b +: 8] <= s_wdata[8*b +: 8];
    end
  end

  task automatic modelReset();
    for (int i = 0; i < 16; i++) refMem[i] = initWord(i);
    expRd[0] = '0;
    expRd[1] = '0;
    favour1 = 1'b0;
  endtask

  task automatic modelGrant(input int g);
    favour1 = (g == 0);
  endtask

  task automatic modelWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) refMem[a[5:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic applyStimulus(input int m, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] ws, input logic rs);
    if (m == 0) begin
      m0_addr = a; m0_wdata = d; m0_wstrb = ws; m0_rstrb = rs;
    end else begin
      m1_addr = a; m1_wdata = d; m1_wstrb = ws; m1_rstrb = rs;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int          kind [2];
    logic [31:0] eAddr [2];
    logic [31:0] eData [2];
    logic [3:0]  eWs [2];
    logic        eRs [2];
    int          order [2];
    int          nServed;
    int          owner;

    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_s_addr", s_addr, 32'd0);
    checkOutput("rst_s_wdata", s_wdata, 32'd0);
    checkOutput("rst_s_wstrb", 32'(s_wstrb), 32'd0);
    checkOutput("rst_s_rstrb", 32'(s_rstrb), 32'd0);
    checkOutput("rst_m0_done", 32'(m0_done), 32'd0);
    checkOutput("rst_m1_done", 32'(m1_done), 32'd0);
    checkOutput("rst_m0_rdata", m0_rdata, 32'd0);
    checkOutput("rst_m1_rdata", m1_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // m0 read of 0x10
    applyStimulus(0, 32'h10, 32'h0, 4'b0, 1'b1);
    #1 checkOutput("rd_m0_busy_win", 32'(m0_busy), 32'd0);
    modelGrant(0);
    @(negedge clk);
    checkOutput("rd_s_rstrb", 32'(s_rstrb), 32'd1);
    checkOutput("rd_s_addr", s_addr, 32'h10);
    checkOutput("rd_grant", 32'(grant), 32'd1);
    checkOutput("rd_early_done", 32'(m0_done), 32'd0);
    @(negedge clk);
    checkOutput("rd_m0_done", 32'(m0_done), 32'd1);
    checkOutput("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
    checkOutput("rd_s_rstrb_clr", 32'(s_rstrb), 32'd0);
    expRd[0] = refMem[4];
    applyStimulus(0, 32'h0, 32'h0, 4'b0, 1'b0);
    @(negedge clk);
    checkOutput("rd_done_pulse", 32'(m0_done), 32'd0);
    checkOutput("rd_rdata_hold", m0_rdata, 32'hDEADBEEF);
    checkOutput("rd_grant_idle", 32'(grant), 32'd0);

    // m1 full-word write of 0x20
    applyStimulus(1, 32'h20, 32'h12345678, 4'b1111, 1'b0);
    modelGrant(1);
    @(negedge clk);
    checkOutput("wr_s_wstrb", 32'(s_wstrb), 32'hF);
    checkOutput("wr_s_wdata", s_wdata, 32'h12345678);
    checkOutput("wr_s_addr", s_addr, 32'h20);
    checkOutput("wr_grant", 32'(grant), 32'd2);
    @(negedge clk);
    checkOutput("wr_m1_done", 32'(m1_done), 32'd1);
    checkOutput("wr_m1_rdata", m1_rdata, 32'd0);
    checkOutput("wr_s_wstrb_clr", 32'(s_wstrb), 32'd0);
    modelWrite(32'h20, 32'h12345678, 4'b1111);
    applyStimulus(1, 32'h0, 32'h0, 4'b0, 1'b0);
    @(negedge clk);

    // Both masters reading continuously
    applyStimulus(0, 32'h10, 32'h0, 4'b0, 1'b1);
    applyStimulus(1, 32'h20, 32'h0, 4'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      owner = RR ? int'(favour1) : 0;
      modelGrant(owner);
      @(negedge clk);
      checkOutput("cont_grant", 32'(grant), (owner == 0) ? 32'd1 : 32'd2);
      checkOutput("cont_s_rstrb", 32'(s_rstrb), 32'd1);
      checkOutput("cont_m1_busy", 32'(m1_busy), (owner == 1) ? 32'd0 : 32'd1);
      @(negedge clk);
      checkOutput("cont_done", 32'(owner == 0 ? m0_done : m1_done), 32'd1);
      checkOutput("cont_rdata", owner == 0 ? m0_rdata : m1_rdata, refMem[owner == 0 ? 4 : 8]);
      expRd[owner] = refMem[owner == 0 ? 4 : 8];
      if (k == 5) begin
        applyStimulus(0, 32'h0, 32'h0, 4'b0, 1'b0);
        applyStimulus(1, 32'h0, 32'h0, 4'b0, 1'b0);
      end
    end
    @(negedge clk);
    checkOutput("cont_idle_grant", 32'(grant), 32'd0);

    // Reset during the ACCESS cycle of an m0 read
    applyStimulus(0, 32'h10, 32'h0, 4'b0, 1'b1);
    @(negedge clk);
    checkOutput("abort_s_rstrb", 32'(s_rstrb), 32'd1);
    rst = 1'b1;
    applyStimulus(0, 32'h0, 32'h0, 4'b0, 1'b0);
    @(negedge clk);
    checkOutput("abort_m0_done", 32'(m0_done), 32'd0);
    checkOutput("abort_m0_rdata", m0_rdata, 32'd0);
    checkOutput("abort_grant", 32'(grant), 32'd0);
    checkOutput("abort_s_rstrb_clr", 32'(s_rstrb), 32'd0);
    rst = 1'b0;
    modelReset();
    @(negedge clk);
    checkOutput("abort_no_late_done", 32'(m0_done), 32'd0);
    checkOutput("abort_rdata_stays", m0_rdata, 32'd0);

    // m1 requests then withdraws while m0 is served
    applyStimulus(0, 32'h10, 32'h0, 4'b0, 1'b1);
    modelGrant(0);
    @(negedge clk);
    checkOutput("wd_grant", 32'(grant), 32'd1);
    applyStimulus(1, 32'h30, 32'h0, 4'b0, 1'b1);
    #1 checkOutput("wd_m1_busy_on", 32'(m1_busy), 32'd1);
    #1 applyStimulus(1, 32'h0, 32'h0, 4'b0, 1'b0);
    #1 checkOutput("wd_m1_busy_off", 32'(m1_busy), 32'd0);
    @(negedge clk);
    checkOutput("wd_m0_done", 32'(m0_done), 32'd1);
    checkOutput("wd_m1_done", 32'(m1_done), 32'd0);
    expRd[0] = refMem[4];
    applyStimulus(0, 32'h0, 32'h0, 4'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checkOutput("wd_no_access", 32'(grant), 32'd0);
      checkOutput("wd_no_m1_done", 32'(m1_done), 32'd0);
      checkOutput("wd_no_strobe", 32'(s_rstrb), 32'd0);
    end

    // Random episodes: each master issues at most one request, both in the same cycle
    for (int ep = 0; ep < 40; ep++) begin
      for (int m = 0; m < 2; m++) begin
        kind[m]  = $urandom_range(0, 3);
        eAddr[m] = 32'($urandom_range(0, 15)) << 2;
        eData[m] = $urandom;
        eWs[m]   = ((kind[m] & 2) != 0) ? 4'($urandom_range(1, 15)) : 4'b0;
        eRs[m]   = ((kind[m] & 1) != 0);
      end
      nServed = 0;
      if (kind[0] != 0 && kind[1] != 0) begin
        order[0] = RR ? int'(favour1) : 0;
        order[1] = 1 - order[0];
        nServed = 2;
      end else if (kind[0] != 0) begin
        order[0] = 0;
        nServed = 1;
      end else if (kind[1] != 0) begin
        order[0] = 1;
        nServed = 1;
      end
      for (int m = 0; m < 2; m++)
        if (kind[m] != 0) applyStimulus(m, eAddr[m], eData[m], eWs[m], eRs[m]);
      for (int j = 0; j < nServed; j++) begin
        owner = order[j];
        modelGrant(owner);
        @(negedge clk);
        checkOutput("rnd_grant", 32'(grant), (owner == 0) ? 32'd1 : 32'd2);
        checkOutput("rnd_s_addr", s_addr, eAddr[owner]);
        checkOutput("rnd_s_rstrb", 32'(s_rstrb), 32'(eRs[owner]));
        checkOutput("rnd_s_wstrb", 32'(s_wstrb), 32'(eWs[owner]));
        if (eWs[owner] != 4'b0) checkOutput("rnd_s_wdata", s_wdata, eData[owner]);
        if (nServed == 2 && j == 0)
          checkOutput("rnd_wait_busy", 32'(owner == 0 ? m1_busy : m0_busy), 32'd1);
        @(negedge clk);
        if (eRs[owner]) expRd[owner] = refMem[eAddr[owner][5:2]];
        modelWrite(eAddr[owner], eData[owner], eWs[owner]);
        checkOutput("rnd_done", 32'(owner == 0 ? m0_done : m1_done), 32'd1);
        checkOutput("rnd_other_done", 32'(owner == 0 ? m1_done : m0_done), 32'd0);
        checkOutput("rnd_rdata", owner == 0 ? m0_rdata : m1_rdata, expRd[owner]);
        applyStimulus(owner, 32'h0, 32'h0, 4'b0, 1'b0);
      end
      @(negedge clk);
      checkOutput("rnd_idle_grant", 32'(grant), 32'd0);
      checkOutput("rnd_idle_done", 32'({m1_done, m0_done}), 32'd0);
      checkOutput("rnd_m0_rdata_hold", m0_rdata, expRd[0]);
      checkOutput("rnd_m1_rdata_hold", m1_rdata, expRd[1]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the address width of all master and slave address ports.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width; strobe width is DATA_W/8.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 m0_addr, m1_addr  input  ADDR_W  master address (m0 = CPU, m1 = loader/DMA).
REQ-006 m0_wdata, m1_wdata  input  DATA_W  master write data.
REQ-007 m0_wstrb, m1_wstrb  input  DATA_W/8  master byte write strobes.
REQ-008 m0_rstrb, m1_rstrb  input  1  master read strobe.
REQ-009 m0_rdata, m1_rdata  output  DATA_W  registered read data per master.
REQ-010 m0_done, m1_done  output  1  one-cycle access-complete pulse per master.
REQ-011 m0_busy, m1_busy  output  1  request pending, not yet granted.
REQ-012 s_addr, s_wdata, s_wstrb, s_rstrb  output  ADDR_W/DATA_W/DATA_W/8/1  registered signals to the shared program memory.
REQ-013 s_rdata  input  DATA_W  memory read data, valid one cycle after s_rstrb.
REQ-014 grant  output  2  one-hot owner of the current access; 2'b00 when idle.

Function
REQ-015 A master request mx_req SHALL be (mx_rstrb | (|mx_wstrb)); the master SHALL hold its signals stable until mx_done.
REQ-016 The FSM SHALL have states IDLE, ACCESS, DONE.
REQ-017 In IDLE or DONE with any request (excluding the master completing in DONE), the FSM SHALL choose a winner, latch its addr/wdata/wstrb/rstrb into s_* registers, set grant, and go to ACCESS; otherwise go to IDLE.
REQ-018 ACCESS SHALL last exactly one cycle with s_* strobes asserted, then go to DONE with s_rstrb and s_wstrb cleared.
REQ-019 In DONE, the owner's mx_done SHALL pulse for one cycle and, for reads, mx_rdata SHALL capture s_rdata; mx_rdata SHALL hold until the next read completion for that master.
REQ-020 Latency: request seen in cycle N (FSM idle) -> slave strobe in N+1 -> done and rdata in N+2.
REQ-021 Back-to-back: winner chosen in DONE SHALL be strobed in the next cycle (throughput one access per 2 cycles).
REQ-022 mx_busy SHALL be mx_req & not (winner latched for x this cycle) & not (x in ACCESS/DONE).
REQ-023 A request withdrawn before grant SHALL produce no access and no done; a latched access SHALL complete regardless of later master input changes.
REQ-024 Simultaneous requests SHALL be resolved per REQ-028/REQ-029; a single requester SHALL always win.
REQ-025 Read and write requested together by one master SHALL issue both strobes in the same ACCESS cycle.

Reset
REQ-026 On rst, the FSM SHALL enter IDLE; s_addr, s_wdata, s_wstrb, s_rstrb, m0_rdata, m1_rdata, m0_done, m1_done, and grant SHALL be 0; the round-robin pointer SHALL favour m0.
REQ-027 rst asserted during ACCESS or DONE SHALL abort: no done pulse and no rdata capture.

Configuration
REQ-028 With MEM_ARBITER_RR_EN defined, arbitration SHALL be round-robin: on contention the master not granted last SHALL win; the pointer updates on each grant.
REQ-029 Without MEM_ARBITER_RR_EN, arbitration SHALL be fixed priority: m0 always wins contention.

Verification
REQ-030 m0 read addr 0x00000010, memory returns 0xDEADBEEF -> s_rstrb high in N+1 with s_addr 0x10; m0_done and m0_rdata=0xDEADBEEF in N+2.
REQ-031 m1 write 0x12345678, wstrb 4'b1111, addr 0x20 -> s_wstrb 4'b1111, s_wdata 0x12345678 in N+1; m1_done in N+2; m1_rdata unchanged.
REQ-032 Both request in the same cycle continuously, RR_EN defined -> grants alternate m0,m1,m0,m1, accesses 2 cycles apart; RR_EN undefined -> m0 every grant, m1_busy stays 1.
REQ-033 rst pulsed in the ACCESS cycle of an m0 read -> no m0_done, m0_rdata=0, grant=0, FSM in IDLE next cycle.
REQ-034 m1 requests then drops its request while m0 is being served -> no m1 access, no m1_done, m1_busy=0 after drop.
